// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - conditional-execution stage: NZCV flag register, condition check, write-enable gating
//
// Holds the architectural {N,Z,C,V} flags, evaluates the instruction
// condition field against them and gates the decoder's write requests.
// Also counts annulled (condition-failed) commits, saturating at all-ones.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   en           commit strobe; low freezes state and zeroes gated outputs
//   Cond         instruction condition field Instr[31:28]
//   ALUFlags     {N,Z,C,V} produced by the ALU for this instruction
//   FlagW        [1] writes N,Z; [0] writes C,V
//   PCS/RegW/MemW/NoWrite  raw decoder requests
//   PCSrc/RegWrite/MemWrite gated architectural write enables
//   CondEx       condition passed (from registered flags only)
//   Flags        registered {N,Z,C,V}
//   AnnulCnt     saturating count of condition-failed commits
module cond_logic #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NoWrite,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] AnnulCnt
);

   logic n, z, c, v;
   logic commit_pass;
   logic commit_fail;

   assign {n, z, c, v} = Flags;

   // Condition evaluated against the stored flags, so a flag-setting
   // instruction never influences its own condition.
   always_comb begin
      CondEx = 1'b0;
      case (Cond)
         4'b0000: CondEx = z;
         4'b0001: CondEx = ~z;
         4'b0010: CondEx = c;
         4'b0011: CondEx = ~c;
         4'b0100: CondEx = n;
         4'b0101: CondEx = ~n;
         4'b0110: CondEx = v;
         4'b0111: CondEx = ~v;
         4'b1000: CondEx = c & ~z;
         4'b1001: CondEx = ~c | z;
         4'b1010: CondEx = (n == v);
         4'b1011: CondEx = (n != v);
         4'b1100: CondEx = ~z & (n == v);
         4'b1101: CondEx = z | (n != v);
         4'b1110: CondEx = 1'b1;
         default: CondEx = 1'b0;
      endcase
   end

   assign commit_pass = en & CondEx;
   assign commit_fail = en & ~CondEx;

   // rst_n is folded in so no write can escape while reset is held,
   // even though the decoder inputs may still be asserting requests.
   assign PCSrc    = PCS  & commit_pass & rst_n;
   assign RegWrite = RegW & ~NoWrite & commit_pass & rst_n;
   assign MemWrite = MemW & commit_pass & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Flags <= 4'b0000;
      end else if (commit_pass) begin
         if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
         if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         AnnulCnt <= '0;
      end else if (commit_fail && (AnnulCnt != {CNT_W{1'b1}})) begin
         AnnulCnt <= AnnulCnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_cond_logic.sv
// tb/tb_cond_logic.sv - self-checking bench for cond_logic
module tb_cond_logic;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS, RegW, MemW, NoWrite;
   logic       PCSrc, RegWrite, MemWrite, CondEx;
   logic [3:0] Flags;
   logic [7:0] AnnulCnt;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   // reference state
   logic [3:0] m_flags;
   int         m_cnt;

   cond_logic #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
      .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
      .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
      .Flags(Flags), .AnnulCnt(AnnulCnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Architectural view: cond[3:1] selects a base test, cond[0] inverts it,
   // 1111 is never-execute.
   function automatic bit ref_cond(input logic [3:0] cd, input logic [3:0] f);
      bit fn, fz, fc, fv, base;
      fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
      case (cd[3:1])
         3'd0: base = fz;
         3'd1: base = fc;
         3'd2: base = fn;
         3'd3: base = fv;
         3'd4: base = fc && !fz;
         3'd5: base = (fn == fv);
         3'd6: base = !fz && (fn == fv);
         default: base = 1'b1;
      endcase
      if (cd == 4'hF) return 1'b0;
      return cd[0] ? !base : base;
   endfunction

   // One commit cycle. Entered and left 1 time unit after a rising edge.
   task automatic commit(input string tag, input logic [3:0] cd, input logic [1:0] fw,
                         input logic [3:0] alu, input logic pcs, input logic regw,
                         input logic memw, input logic nw, input logic e);
      bit ce;
      Cond = cd; FlagW = fw; ALUFlags = alu; PCS = pcs; RegW = regw;
      MemW = memw; NoWrite = nw; en = e;
      #2;
      ce = ref_cond(cd, m_flags);
      chk({tag, "_condex"}, 32'(CondEx), 32'(ce));
      chk({tag, "_pcsrc"}, 32'(PCSrc), 32'(pcs && ce && e));
      chk({tag, "_regwrite"}, 32'(RegWrite), 32'(regw && ce && !nw && e));
      chk({tag, "_memwrite"}, 32'(MemWrite), 32'(memw && ce && e));
      if (e && ce) begin
         if (fw[1]) m_flags[3:2] = alu[3:2];
         if (fw[0]) m_flags[1:0] = alu[1:0];
      end
      if (e && !ce && m_cnt < 255) m_cnt++;
      @(posedge clk); #1;
      chk({tag, "_flags"}, 32'(Flags), 32'(m_flags));
      chk({tag, "_cnt"}, 32'(AnnulCnt), 32'(m_cnt));
   endtask

   initial begin
      // Reset with every request asserted
      rst_n = 1'b0; en = 1'b1; Cond = 4'hE; ALUFlags = 4'h0; FlagW = 2'b00;
      PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NoWrite = 1'b0;
      m_flags = 4'h0; m_cnt = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pcsrc", 32'(PCSrc), 32'd0);
      chk("rst_regwrite", 32'(RegWrite), 32'd0);
      chk("rst_memwrite", 32'(MemWrite), 32'd0);
      chk("rst_flags", 32'(Flags), 32'd0);
      chk("rst_cnt", 32'(AnnulCnt), 32'd0);
      chk("rst_condex_al", 32'(CondEx), 32'd1);
      rst_n = 1'b1;
      #1;
      chk("rel_pcsrc", 32'(PCSrc), 32'd1);
      chk("rel_regwrite", 32'(RegWrite), 32'd1);
      chk("rel_memwrite", 32'(MemWrite), 32'd1);
      @(posedge clk); #1;

      // CMP then BEQ / BNE
      commit("cmp", 4'hE, 2'b11, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("cmp_flags_const", 32'(Flags), 32'h4);
      commit("beq", 4'h0, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      commit("bne", 4'h1, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("bne_cnt_const", 32'(AnnulCnt), 32'd1);

      // Partial flag writes
      commit("setall", 4'hE, 2'b11, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      commit("fw10", 4'hE, 2'b10, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("fw10_const", 32'(Flags), 32'h3);
      commit("fw01", 4'hE, 2'b01, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("fw01_const", 32'(Flags), 32'h0);

      // Failed condition must not write flags or memory
      commit("failw", 4'h0, 2'b11, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("failw_flags_const", 32'(Flags), 32'h0);

      // Randomized commits against the model
      for (int i = 0; i < 200; i++) begin
         commit("rnd", 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      end

      // Exhaustive sweep: load each flag value, then probe every condition with en low
      for (int f = 0; f < 16; f++) begin
         commit("load", 4'hE, 2'b11, 4'(f), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         en = 1'b0; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NoWrite = 1'b0;
         for (int cd = 0; cd < 16; cd++) begin
            Cond = 4'(cd);
            #1;
            chk("sweep_condex", 32'(CondEx), 32'(ref_cond(4'(cd), 4'(f))));
            chk("sweep_en0_gate", 32'({PCSrc, RegWrite, MemWrite}), 32'd0);
         end
         @(posedge clk); #1;
         chk("sweep_en0_hold", 32'(Flags), 32'(m_flags));
      end

      // Saturation
      for (int i = 0; i < 300; i++)
         commit("sat", 4'hF, 2'b11, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("sat_const", 32'(AnnulCnt), 32'd255);

      // Mid-cycle reset with a pending annul and a pending flag write request
      Cond = 4'hE; en = 1'b1; FlagW = 2'b11; ALUFlags = 4'hF;
      PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NoWrite = 1'b0;
      commit("pre", 4'hE, 2'b11, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'hF; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_cnt", 32'(AnnulCnt), 32'd0);
      chk("mid_rst_flags", 32'(Flags), 32'd0);
      chk("mid_rst_gate", 32'({PCSrc, RegWrite, MemWrite}), 32'd0);
      @(posedge clk); #1;
      chk("mid_rst_hold_flags", 32'(Flags), 32'd0);
      chk("mid_rst_hold_cnt", 32'(AnnulCnt), 32'd0);
      rst_n = 1'b1;
      m_flags = 4'h0; m_cnt = 0;
      commit("post", 4'h0, 2'b00, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed no_finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cond_logic.md
# cond_logic

Conditional-execution stage that sits directly downstream of the instruction decoder in the single-cycle ARM datapath. It holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against the stored flags. It gates the decoder's raw PCS/RegW/MemW requests into the architectural write enables PCSrc/RegWrite/MemWrite and updates the flags from the ALU according to FlagW. It also keeps a saturating count of annulled (condition-failed) instructions for debug.

## Interface
- CNT_W, 8, width of the annulled-instruction counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  instruction commit strobe; tie 1 in single-cycle use, driven by control FSM in multicycle use
- Cond  input  4  instruction condition field, Instr[31:28]
- ALUFlags  input  4  ALU result flags {N,Z,C,V} of the current instruction
- FlagW  input  2  from decoder; [1] enables N,Z update, [0] enables C,V update
- PCS  input  1  from decoder; instruction writes PC
- RegW  input  1  from decoder; instruction writes register file
- MemW  input  1  from decoder; instruction writes data memory
- NoWrite  input  1  from decoder; suppress register write (CMP)
- PCSrc  output  1  gated PC-write select
- RegWrite  output  1  gated register-file write enable
- MemWrite  output  1  gated data-memory write enable
- CondEx  output  1  condition passed for current instruction
- Flags  output  4  current registered {N,Z,C,V}
- AnnulCnt  output  CNT_W  saturating count of committed instructions whose condition failed

## Operation
- CondEx is combinational from Cond and the registered Flags (never from ALUFlags):
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0
- Gating is combinational, qualified by en:
  - PCSrc = PCS & CondEx & en
  - RegWrite = RegW & CondEx & ~NoWrite & en
  - MemWrite = MemW & CondEx & en
- Flag update at a rising clk edge when en & CondEx:
  - FlagW[1]: Flags[3:2] <= ALUFlags[3:2]
  - FlagW[0]: Flags[1:0] <= ALUFlags[1:0]
  - Bits not enabled hold their value. Both bits set updates all four.
- AnnulCnt increments by 1 at a rising edge when en & ~CondEx. It saturates at 2^CNT_W-1 and never wraps.
- A condition-failed instruction writes nothing: no flags, no PC, no register, no memory.

## Timing
- Reset (rst_n low, asynchronous assert):
  - Flags = 4'b0000 and AnnulCnt = 0 immediately.
  - PCSrc, RegWrite and MemWrite are forced 0 while rst_n is low, regardless of the other inputs.
  - CondEx still reflects Cond against Flags = 0000.
- Reset deassertion is synchronised externally. The first edge with rst_n high may update state.
- Gated outputs have zero-cycle latency from Cond, PCS, RegW, MemW, NoWrite and en.
- Flags updated at edge k are seen by CondEx from cycle k+1 onward. A flag-setting instruction never affects its own condition.
- A conditional instruction directly after a flag-setting instruction sees the new flags with no bubble.
- Reset asserted mid-cycle discards any pending flag or counter update for that cycle.
- en low: no state changes and all gated outputs are 0.

## Test plan
- Reset: hold rst_n=0 with PCS=RegW=MemW=1 and Cond=1110 -> PCSrc=RegWrite=MemWrite=0, Flags=0000, AnnulCnt=0. After release, the same inputs give all three gated outputs = 1.
- CMP then BEQ:
  - Cycle 1: Cond=1110, FlagW=11, NoWrite=1, RegW=1, ALUFlags=0100 -> RegWrite=0. After the edge, Flags=0100.
  - Cycle 2: Cond=0000, PCS=1 -> PCSrc=1. With Cond=0001 instead -> PCSrc=0 and AnnulCnt increments by 1.
- Partial flag write: start with Flags=1111; apply FlagW=10 and ALUFlags=0000 -> Flags=0011. Then apply FlagW=01 and ALUFlags=0000 -> Flags=0000.
- Failed condition blocks the flag write: Flags=0000, Cond=0000, FlagW=11, ALUFlags=1111, MemW=1 -> MemWrite=0 and Flags stay 0000.
- Exhaustive condition sweep: all 16 Cond values × all 16 Flags values checked against a reference model. Cond=1111 always gives CondEx=0.
- Counter saturation and mid-operation reset: with CNT_W=8, run 300 annulled commits -> AnnulCnt=255 and held. Assert rst_n mid-cycle -> AnnulCnt=0 asynchronously.
